pipeline_perf_monitor: RTL and testbench
========================================

# pipeline_perf_monitor

Synthesizable performance and end-of-test monitor for the 5-stage RISCVCPU pipeline. It counts cycles, retirements, branches, jumps, flushes, stalls and N generic event channels. It detects program halt (a retired halt instruction) and hang (a watchdog with no retirement). It sits beside the core, is fed from the WB/EX stage tap signals, and replaces per-cycle bench printing with registered counters and a clean done/timeout indication.

## Interface
- CNT_W, 32: width of every counter
- PC_W, 32: width of PC values
- N_EVT, 4: number of generic event channels
- WDOG_CYC, 1024: cycles without retirement before timeout (≥2)
- HALT_INSN, 32'h0000_0073: instruction encoding treated as halt (ecall)
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; all state is cleared when low at a rising edge
- start  in  1  one-cycle pulse; IDLE→RUN
- clear  in  1  zero all counters and watchdog; state unchanged
- retire_valid  in  1  instruction retired at WB this cycle
- retire_pc  in  PC_W  PC of the retired instruction
- retire_insn  in  32  encoding of the retired instruction
- br_valid  in  1  conditional branch resolved in EX
- br_taken  in  1  that branch was taken (qualified by br_valid)
- jmp_valid  in  1  JAL/JALR resolved in EX
- flush  in  1  pipeline flush this cycle
- stall  in  1  IF/ID stall this cycle
- evt  in  N_EVT  generic event strobes
- cycle_cnt, retired_cnt, br_cnt, br_taken_cnt, jmp_cnt, flush_cnt, stall_cnt  out  CNT_W each  counters
- evt_cnt  out  N_EVT×CNT_W  per-channel counters, channel i at bits [i*CNT_W +: CNT_W]
- last_pc  out  PC_W  PC of the most recent retirement
- state  out  2  FSM state encoding
- done  out  1  high while in HALTED
- timeout  out  1  high while in TIMEOUT

## Operation
- FSM states: IDLE(0), RUN(1), HALTED(2), TIMEOUT(3).
- IDLE→RUN on start. RUN→HALTED on retire_valid && retire_insn==HALT_INSN. RUN→TIMEOUT when wdog reaches WDOG_CYC−1 and there is no retirement this cycle. HALTED and TIMEOUT are sticky; only reset leaves them. start outside IDLE is ignored.
- Counters increment only in RUN and only on their qualified strobe:
  - cycle_cnt counts every RUN cycle.
  - br_taken_cnt counts on br_valid&&br_taken.
  - br_taken without br_valid is ignored.
  - The halting instruction itself counts in retired_cnt and updates last_pc.
- All counters saturate at 2^CNT_W−1; they do not wrap.
- Watchdog: internal counter that clears on any retire_valid in RUN and otherwise increments in RUN.
- clear zeroes every counter and the watchdog; last_pc is held. If clear and an event occur in the same cycle, clear wins and the counter is 0 next cycle.
- Outputs hold their values in IDLE, HALTED and TIMEOUT. They remain readable after the end of the test.

## Timing
- All outputs are registered. A strobe at edge k is visible on the counter output after edge k, with 1-cycle latency.
- A start pulse at edge k puts state=RUN after k. The first cycle_cnt increment happens at edge k+1.
- Halt retirement at edge k: state=HALTED and done=1 after k. Counters are frozen from edge k+1 on.
- Timeout: with the last retirement at edge k and none after it, timeout=1 after edge k+WDOG_CYC.
- reset low at any edge, mid-run included: the next cycle has state=IDLE and all counters, last_pc, done and timeout equal to 0. Inputs are ignored while reset is low.

## Structure
- Shared package perf_pkg holds:
  - typedef enum logic[1:0] perf_state_t {IDLE, RUN, HALTED, TIMEOUT}
  - the HALT_INSN default constant
- Sub-module sat_counter (parameter W; inputs clock, reset, clr, inc; output q) is instantiated for every counter, including the generate loop over N_EVT.
- The top holds the FSM, the watchdog and last_pc.

## Test plan
- Reset, start, then 5 retirements (pc 0x0,4,8,C,10) followed by retirement of 0x00000073 at pc 0x14 → done=1, retired_cnt=6, last_pc=0x14; cycle_cnt frozen for 3 further cycles.
- Set br_valid on 4 cycles, br_taken on 3 of them, plus one cycle with br_taken alone; add 2 jmp_valid → br_cnt=4, br_taken_cnt=3, jmp_cnt=2.
- WDOG_CYC=8: one retirement, then none → timeout=1 exactly 8 cycles after the retirement edge, state=3, done=0.
- CNT_W=4: hold stall high for 20 RUN cycles → stall_cnt=15 and stays at 15.
- clear coincident with flush and evt[2] → flush_cnt=0, evt_cnt[2]=0, last_pc unchanged; the next evt[2] gives 1.
- reset asserted mid-RUN with cycle_cnt=37 → next cycle state=IDLE, all counters 0; pulse evt before start → evt_cnt stays 0.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and constants for the pipeline performance monitor.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } perf_state_t;

    // ecall is used as the end-of-program marker by the test programs.
    localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0000_0073;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for every monitor counter.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear has priority over an increment in the same cycle; all-ones is sticky.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Performance and end-of-test monitor for the 5-stage pipeline: event counters,
// halt detection on a retired ecall, and a no-retirement watchdog.
module pipeline_perf_monitor
    import perf_pkg::*;
#(
    parameter int          CNT_W     = 32,
    parameter int          PC_W      = 32,
    parameter int          N_EVT     = 4,
    parameter int          WDOG_CYC  = 1024,
    parameter logic [31:0] HALT_INSN = HALT_INSN_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   clear,
    input  logic                   retire_valid,
    input  logic [PC_W-1:0]        retire_pc,
    input  logic [31:0]            retire_insn,
    input  logic                   br_valid,
    input  logic                   br_taken,
    input  logic                   jmp_valid,
    input  logic                   flush,
    input  logic                   stall,
    input  logic [N_EVT-1:0]       evt,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       retired_cnt,
    output logic [CNT_W-1:0]       br_cnt,
    output logic [CNT_W-1:0]       br_taken_cnt,
    output logic [CNT_W-1:0]       jmp_cnt,
    output logic [CNT_W-1:0]       flush_cnt,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [N_EVT*CNT_W-1:0] evt_cnt,
    output logic [PC_W-1:0]        last_pc,
    output logic [1:0]             state,
    output logic                   done,
    output logic                   timeout
);

    localparam int               WDOG_W    = $clog2(WDOG_CYC);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

    perf_state_t       state_q, state_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [PC_W-1:0]   last_pc_q, last_pc_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic run;
    logic is_halt;

    assign run     = (state_q == RUN);
    assign is_halt = retire_valid && (retire_insn == HALT_INSN);

    // HALTED and TIMEOUT are terminal until reset; a halt retirement beats the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (is_halt) begin
                    state_d = HALTED;
                end else if (!retire_valid && (wdog_q == WDOG_LAST)) begin
                    state_d = TIMEOUT;
                end
            end
            HALTED:  state_d = state_q;
            TIMEOUT: state_d = state_q;
            default: state_d = IDLE;
        endcase
        done_d    = (state_d == HALTED);
        timeout_d = (state_d == TIMEOUT);
    end

    always_comb begin
        wdog_d    = wdog_q;
        last_pc_d = last_pc_q;
        if (clear) begin
            wdog_d = '0;
        end else if (run) begin
            wdog_d = retire_valid ? '0 : (wdog_q + WDOG_W'(1));
        end
        if (run && retire_valid) begin
            last_pc_d = retire_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            wdog_q    <= '0;
            last_pc_q <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            last_pc_q <= last_pc_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock(clock), .reset(reset), .clr(clear), .inc(run), .q(cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retired_cnt (
        .clock(clock), .reset(reset), .clr(clear), .inc(run && retire_valid), .q(retired_cnt)
    );

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clock(clock), .reset(reset), .clr(clear), .inc(run && br_valid), .q(br_cnt)
    );

    sat_counter #(.W(CNT_W)) u_br_taken_cnt (
        .clock(clock), .reset(reset), .clr(clear), .inc(run && br_valid && br_taken),
        .q(br_taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_jmp_cnt (
        .clock(clock), .reset(reset), .clr(clear), .inc(run && jmp_valid), .q(jmp_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock(clock), .reset(reset), .clr(clear), .inc(run && flush), .q(flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock(clock), .reset(reset), .clr(clear), .inc(run && stall), .q(stall_cnt)
    );

    for (genvar i = 0; i < N_EVT; i++) begin : g_evt
        sat_counter #(.W(CNT_W)) u_evt_cnt (
            .clock(clock), .reset(reset), .clr(clear), .inc(run && evt[i]),
            .q(evt_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign last_pc = last_pc_q;
    assign state   = state_q;
    assign done    = done_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Directed bench for pipeline_perf_monitor: a full-width and a 4-bit-counter
// instance share stimulus and are checked every cycle against an event-count model.
module tb_pipeline_perf_monitor;

    localparam int          WDOG   = 8;
    localparam int          NEVT   = 4;
    localparam logic [31:0] HALT   = 32'h0000_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, clear, retire_valid, br_valid, br_taken, jmp_valid, flush, stall;
    logic [31:0] retire_pc, retire_insn;
    logic [3:0]  evt;

    logic [31:0]  m_cycle, m_retired, m_br, m_br_taken, m_jmp, m_flush, m_stall;
    logic [127:0] m_evt_cnt;
    logic [31:0]  m_last_pc;
    logic [1:0]   m_state_o;
    logic         m_done, m_timeout;

    logic [3:0]  s_cycle, s_retired, s_br, s_br_taken, s_jmp, s_flush, s_stall;
    logic [15:0] s_evt_cnt;
    logic [31:0] s_last_pc;
    logic [1:0]  s_state_o;
    logic        s_done, s_timeout;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clock = ~clock;

    pipeline_perf_monitor #(
        .CNT_W(32), .PC_W(32), .N_EVT(NEVT), .WDOG_CYC(WDOG), .HALT_INSN(HALT)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .clear(clear),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_insn(retire_insn),
        .br_valid(br_valid), .br_taken(br_taken), .jmp_valid(jmp_valid),
        .flush(flush), .stall(stall), .evt(evt),
        .cycle_cnt(m_cycle), .retired_cnt(m_retired), .br_cnt(m_br),
        .br_taken_cnt(m_br_taken), .jmp_cnt(m_jmp), .flush_cnt(m_flush),
        .stall_cnt(m_stall), .evt_cnt(m_evt_cnt), .last_pc(m_last_pc),
        .state(m_state_o), .done(m_done), .timeout(m_timeout)
    );

    pipeline_perf_monitor #(
        .CNT_W(4), .PC_W(32), .N_EVT(NEVT), .WDOG_CYC(WDOG), .HALT_INSN(HALT)
    ) dut_small (
        .clock(clock), .reset(reset), .start(start), .clear(clear),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_insn(retire_insn),
        .br_valid(br_valid), .br_taken(br_taken), .jmp_valid(jmp_valid),
        .flush(flush), .stall(stall), .evt(evt),
        .cycle_cnt(s_cycle), .retired_cnt(s_retired), .br_cnt(s_br),
        .br_taken_cnt(s_br_taken), .jmp_cnt(s_jmp), .flush_cnt(s_flush),
        .stall_cnt(s_stall), .evt_cnt(s_evt_cnt), .last_pc(s_last_pc),
        .state(s_state_o), .done(s_done), .timeout(s_timeout)
    );

    // Model: raw event counts since the last clear/reset; a W-bit counter shows min(raw, 2^W-1).
    // The watchdog is modelled as the edge number of the last retirement/start/clear.
    longint      raw_cnt [7];
    longint      raw_evt [NEVT];
    int          exp_state;
    logic [31:0] exp_last_pc;
    int          edge_num = 0;
    int          ref_edge = 0;
    bit          model_live = 1'b0;

    task automatic model_step();
        bit timed_out;
        int prev_state;
        edge_num++;
        if (!reset) begin
            exp_state   = 0;
            exp_last_pc = '0;
            foreach (raw_cnt[i]) raw_cnt[i] = 0;
            foreach (raw_evt[i]) raw_evt[i] = 0;
            ref_edge   = edge_num;
            model_live = 1'b1;
            return;
        end
        prev_state = exp_state;
        timed_out  = (exp_state == 1) && !retire_valid && ((edge_num - ref_edge) == WDOG);
        if (clear) begin
            foreach (raw_cnt[i]) raw_cnt[i] = 0;
            foreach (raw_evt[i]) raw_evt[i] = 0;
            ref_edge = edge_num;
        end else if (exp_state == 1) begin
            raw_cnt[0]++;
            if (retire_valid)          raw_cnt[1]++;
            if (br_valid)              raw_cnt[2]++;
            if (br_valid && br_taken)  raw_cnt[3]++;
            if (jmp_valid)             raw_cnt[4]++;
            if (flush)                 raw_cnt[5]++;
            if (stall)                 raw_cnt[6]++;
            for (int i = 0; i < NEVT; i++) if (evt[i]) raw_evt[i]++;
        end
        if (exp_state == 1 && retire_valid) begin
            exp_last_pc = retire_pc;
            ref_edge    = edge_num;
        end
        if (prev_state == 0 && start) begin
            exp_state = 1;
            ref_edge  = edge_num;
        end else if (prev_state == 1) begin
            if (retire_valid && retire_insn == HALT) exp_state = 2;
            else if (timed_out)                      exp_state = 3;
        end
    endtask

    always @(posedge clock) model_step();

    function automatic logic [31:0] sat(input longint raw, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (raw > mx) ? mx[31:0] : raw[31:0];
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check_output("state",     32'(m_state_o), 32'(exp_state));
        check_output("done",      32'(m_done),    32'(exp_state == 2));
        check_output("timeout",   32'(m_timeout), 32'(exp_state == 3));
        check_output("last_pc",   m_last_pc,      exp_last_pc);
        check_output("cycle_cnt", m_cycle,        sat(raw_cnt[0], 32));
        check_output("retired",   m_retired,      sat(raw_cnt[1], 32));
        check_output("br_cnt",    m_br,           sat(raw_cnt[2], 32));
        check_output("br_taken",  m_br_taken,     sat(raw_cnt[3], 32));
        check_output("jmp_cnt",   m_jmp,          sat(raw_cnt[4], 32));
        check_output("flush_cnt", m_flush,        sat(raw_cnt[5], 32));
        check_output("stall_cnt", m_stall,        sat(raw_cnt[6], 32));
        for (int i = 0; i < NEVT; i++)
            check_output($sformatf("evt_cnt%0d", i), m_evt_cnt[i*32 +: 32], sat(raw_evt[i], 32));
        check_output("s_state",   32'(s_state_o), 32'(exp_state));
        check_output("s_done",    32'(s_done),    32'(exp_state == 2));
        check_output("s_timeout", 32'(s_timeout), 32'(exp_state == 3));
        check_output("s_last_pc", s_last_pc,      exp_last_pc);
        check_output("s_cycle",   32'(s_cycle),   sat(raw_cnt[0], 4));
        check_output("s_retired", 32'(s_retired), sat(raw_cnt[1], 4));
        check_output("s_br",      32'(s_br),      sat(raw_cnt[2], 4));
        check_output("s_br_tk",   32'(s_br_taken), sat(raw_cnt[3], 4));
        check_output("s_jmp",     32'(s_jmp),     sat(raw_cnt[4], 4));
        check_output("s_flush",   32'(s_flush),   sat(raw_cnt[5], 4));
        check_output("s_stall",   32'(s_stall),   sat(raw_cnt[6], 4));
        for (int i = 0; i < NEVT; i++)
            check_output($sformatf("s_evt_cnt%0d", i), 32'(s_evt_cnt[i*4 +: 4]), sat(raw_evt[i], 4));
    endtask

    always @(negedge clock) if (model_live) check_all();

    // Drives one cycle of inputs (called at a falling edge), returns at the next falling edge.
    task automatic apply_stimulus(
        input logic st = 1'b0, input logic clr = 1'b0, input logic rv = 1'b0,
        input logic [31:0] pc = 32'h0, input logic [31:0] insn = NOP,
        input logic bv = 1'b0, input logic bt = 1'b0, input logic jv = 1'b0,
        input logic fl = 1'b0, input logic stl = 1'b0, input logic [3:0] ev = 4'h0
    );
        start = st; clear = clr; retire_valid = rv; retire_pc = pc; retire_insn = insn;
        br_valid = bv; br_taken = bt; jmp_valid = jv; flush = fl; stall = stl; evt = ev;
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        apply_stimulus();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        start = 0; clear = 0; retire_valid = 0; retire_pc = 0; retire_insn = NOP;
        br_valid = 0; br_taken = 0; jmp_valid = 0; flush = 0; stall = 0; evt = 0;
        @(negedge clock);
        pulse_reset();
        check_output("rst_state", 32'(m_state_o), 32'd0);
        check_output("rst_cycle", m_cycle, 32'd0);

        // Halt program: five instructions then ecall at 0x14.
        apply_stimulus(.st(1'b1));
        check_output("start_state", 32'(m_state_o), 32'd1);
        check_output("start_cycle", m_cycle, 32'd0);
        for (int i = 0; i < 5; i++) apply_stimulus(.rv(1'b1), .pc(32'(i * 4)));
        apply_stimulus(.rv(1'b1), .pc(32'h14), .insn(HALT));
        check_output("halt_done", 32'(m_done), 32'd1);
        check_output("halt_state", 32'(m_state_o), 32'd2);
        check_output("halt_retired", m_retired, 32'd6);
        check_output("halt_last_pc", m_last_pc, 32'h14);
        check_output("halt_cycle", m_cycle, 32'd6);
        for (int i = 0; i < 3; i++) apply_stimulus(.rv(1'b1), .pc(32'h100), .stl(1'b1));
        check_output("halt_frozen_cycle", m_cycle, 32'd6);
        check_output("halt_frozen_pc", m_last_pc, 32'h14);

        // Branch / jump qualification.
        pulse_reset();
        apply_stimulus(.st(1'b1));
        apply_stimulus(.rv(1'b1), .pc(32'h0), .bv(1'b1), .bt(1'b1));
        apply_stimulus(.rv(1'b1), .pc(32'h4), .bv(1'b1), .bt(1'b1));
        apply_stimulus(.rv(1'b1), .pc(32'h8), .bv(1'b1));
        apply_stimulus(.rv(1'b1), .pc(32'hC), .bv(1'b1), .bt(1'b1));
        apply_stimulus(.rv(1'b1), .pc(32'h10), .bt(1'b1));
        apply_stimulus(.rv(1'b1), .pc(32'h14), .jv(1'b1));
        apply_stimulus(.rv(1'b1), .pc(32'h18), .jv(1'b1));
        check_output("br_cnt_lit", m_br, 32'd4);
        check_output("br_taken_lit", m_br_taken, 32'd3);
        check_output("jmp_cnt_lit", m_jmp, 32'd2);

        // Watchdog: one retirement then silence.
        pulse_reset();
        apply_stimulus(.st(1'b1));
        apply_stimulus(.rv(1'b1), .pc(32'h100));
        for (int j = 1; j <= WDOG; j++) begin
            apply_stimulus();
            check_output($sformatf("wdog_timeout_%0d", j), 32'(m_timeout), 32'(j == WDOG));
        end
        check_output("wdog_state", 32'(m_state_o), 32'd3);
        check_output("wdog_done", 32'(m_done), 32'd0);
        apply_stimulus(.st(1'b1));
        apply_stimulus(.rv(1'b1), .pc(32'h200), .insn(HALT));
        check_output("wdog_sticky", 32'(m_state_o), 32'd3);
        check_output("wdog_last_pc", m_last_pc, 32'h100);

        // Saturation of the 4-bit instance.
        pulse_reset();
        apply_stimulus(.st(1'b1));
        for (int i = 0; i < 20; i++) apply_stimulus(.rv(1'b1), .pc(32'(i * 4)), .stl(1'b1));
        check_output("sat_stall_small", 32'(s_stall), 32'd15);
        check_output("sat_stall_full", m_stall, 32'd20);
        for (int i = 0; i < 3; i++) apply_stimulus(.rv(1'b1), .pc(32'h80), .stl(1'b1));
        check_output("sat_stall_hold", 32'(s_stall), 32'd15);

        // Clear colliding with events.
        pulse_reset();
        apply_stimulus(.st(1'b1));
        apply_stimulus(.rv(1'b1), .pc(32'h40), .fl(1'b1), .ev(4'h4));
        apply_stimulus(.fl(1'b1), .ev(4'h4));
        check_output("pre_clear_flush", m_flush, 32'd2);
        apply_stimulus(.clr(1'b1), .fl(1'b1), .ev(4'h4));
        check_output("clear_flush", m_flush, 32'd0);
        check_output("clear_evt2", m_evt_cnt[64 +: 32], 32'd0);
        check_output("clear_last_pc", m_last_pc, 32'h40);
        apply_stimulus(.ev(4'h4));
        check_output("post_clear_evt2", m_evt_cnt[64 +: 32], 32'd1);

        // Reset in the middle of a run.
        pulse_reset();
        apply_stimulus(.st(1'b1));
        for (int i = 0; i < 37; i++) apply_stimulus(.rv(1'b1), .pc(32'(i * 4)), .ev(4'(i)));
        check_output("mid_cycle", m_cycle, 32'd37);
        pulse_reset();
        check_output("mid_rst_state", 32'(m_state_o), 32'd0);
        check_output("mid_rst_cycle", m_cycle, 32'd0);
        check_output("mid_rst_retired", m_retired, 32'd0);
        check_output("mid_rst_last_pc", m_last_pc, 32'd0);
        apply_stimulus(.ev(4'hF), .rv(1'b1), .pc(32'h44));
        for (int i = 0; i < NEVT; i++)
            check_output($sformatf("idle_evt%0d", i), m_evt_cnt[i*32 +: 32], 32'd0);
        check_output("idle_last_pc", m_last_pc, 32'd0);

        apply_stimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
